// File: rtl/looper_pipe_pkg.sv
// ---------------------------------------------------------------------------
// looper_pipe_pkg
// Shared definitions for the RF->EX pipeline control logic:
//   - ctrl_state_e : EX-stage control FSM state encoding (RUN/MULT/MEM/FLUSH)
//   - fu_idx_e     : bit positions of each functional unit in issue-valid vectors
//   - MULT_LAT_MIN / MULT_LAT_MAX : legal bounds of the multiply latency
//   - MULT_CNT_W   : width of the multiply down-counter
//   - mult_load()  : counter preload value for a given multiply latency
// ---------------------------------------------------------------------------
package looper_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MULT  = 2'd1,
        ST_MEM   = 2'd2,
        ST_FLUSH = 2'd3
    } ctrl_state_e;

    typedef enum int unsigned {
        FU_ALU1 = 0,
        FU_ALU2 = 1,
        FU_MULT = 2,
        FU_ADDR = 3
    } fu_idx_e;

    localparam int MULT_LAT_MIN = 2;
    localparam int MULT_LAT_MAX = 8;

    // Counter only ever holds MULT_LAT-1, i.e. at most MULT_LAT_MAX-1 = 7.
    localparam int MULT_CNT_W = 3;

    // The capture cycle itself is the first EX cycle of a multiply, so the
    // counter is preloaded with the number of remaining cycles.
    function automatic logic [MULT_CNT_W-1:0] mult_load(input int lat);
        return MULT_CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/sat_cnt16.sv
// ---------------------------------------------------------------------------
// sat_cnt16
// 16-bit up-counter that sticks at 16'hFFFF instead of wrapping.
// Ports:
//   i_clk : clock, rising edge
//   i_clr : asynchronous active-high clear to zero
//   i_inc : count enable, one increment per cycle while high
//   o_cnt : current count
// ---------------------------------------------------------------------------
module sat_cnt16 (
    input  logic        i_clk,
    input  logic        i_clr,
    input  logic        i_inc,
    output logic [15:0] o_cnt
);

    logic [15:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/rf_ex_ctrl.sv
// ---------------------------------------------------------------------------
// rf_ex_ctrl
// Control for the RF_EX pipeline register: holds it while a multi-cycle
// multiply or an outstanding data-memory access occupies EX, inserts a single
// bubble on a branch-mispredict flush, and counts stalled cycles.
// Parameter:
//   MULT_LAT   : total EX cycles of a multiply (2..8)
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   issue_vld  : per-FU valid from RF (bit0 alu1, bit1 alu2, bit2 mult, bit3 addr)
//   addr_mem_op: addr-unit instruction is a load/store
//   dcache_rdy : data memory finished the outstanding access
//   flush      : mispredict flush, highest priority
//   rf_ex_en   : write enable for all RF_EX flops
//   fu_vld_out : gated valid bits written into RF_EX
//   stall_up   : hold request to issue/RF
//   ctrl_state : FSM state (debug)
//   stall_cnt  : saturating stalled-cycle count
// ---------------------------------------------------------------------------
module rf_ex_ctrl
    import looper_pipe_pkg::*;
#(
    parameter int MULT_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  issue_vld,
    input  logic        addr_mem_op,
    input  logic        dcache_rdy,
    input  logic        flush,
    output logic        rf_ex_en,
    output logic [3:0]  fu_vld_out,
    output logic        stall_up,
    output logic [1:0]  ctrl_state,
    output logic [15:0] stall_cnt
);

    generate
        if ((MULT_LAT < MULT_LAT_MIN) || (MULT_LAT > MULT_LAT_MAX)) begin : g_bad_lat
            $error("rf_ex_ctrl: MULT_LAT out of range");
        end
    endgenerate

    localparam logic [MULT_CNT_W-1:0] LP_MULT_LOAD = mult_load(MULT_LAT);

    ctrl_state_e           r_state;
    logic [MULT_CNT_W-1:0] r_mult_cnt;
    logic                  r_mem_pend;

    ctrl_state_e           w_state_nxt;
    logic [MULT_CNT_W-1:0] w_mult_cnt_nxt;
    logic                  w_mem_pend_nxt;
    logic                  w_capture;
    logic                  w_mem_cap;

    // rf_ex_en is always 1 in RUN, so capture reduces to RUN and no flush.
    assign w_capture = (r_state == ST_RUN) && !flush;
    assign w_mem_cap = w_capture && issue_vld[FU_ADDR] && addr_mem_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_mult_cnt <= '0;
            r_mem_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mult_cnt <= w_mult_cnt_nxt;
            r_mem_pend <= w_mem_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_mult_cnt_nxt = r_mult_cnt;
        w_mem_pend_nxt = r_mem_pend;

        case (r_state)
            ST_RUN: begin
                if (w_capture) begin
                    if (issue_vld[FU_MULT]) begin
                        w_state_nxt    = ST_MULT;
                        w_mult_cnt_nxt = LP_MULT_LOAD;
                    end else if (w_mem_cap && !dcache_rdy) begin
                        w_state_nxt = ST_MEM;
                    end
                end
                if (w_mem_cap) begin
                    w_mem_pend_nxt = 1'b1;
                end
            end
            ST_MULT: begin
                w_mult_cnt_nxt = r_mult_cnt - 1'b1;
                if (r_mult_cnt == MULT_CNT_W'(1)) begin
                    // A memory access captured alongside the multiply is only
                    // waited on if it has not already completed meanwhile.
                    w_state_nxt = (r_mem_pend && !dcache_rdy) ? ST_MEM : ST_RUN;
                end
            end
            ST_MEM: begin
                if (dcache_rdy) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        // Completion wins over a same-cycle capture: the access is done.
        if (dcache_rdy) begin
            w_mem_pend_nxt = 1'b0;
        end

        if (flush) begin
            w_state_nxt    = ST_FLUSH;
            w_mult_cnt_nxt = '0;
            w_mem_pend_nxt = 1'b0;
        end
    end

    always_comb begin
        rf_ex_en   = 1'b1;
        stall_up   = 1'b0;
        fu_vld_out = '0;
        case (r_state)
            ST_RUN: begin
                // While in reset the valids pass straight through.
                fu_vld_out = (flush && !rst) ? 4'b0000 : issue_vld;
            end
            ST_MULT, ST_MEM: begin
                rf_ex_en = 1'b0;
                stall_up = 1'b1;
            end
            ST_FLUSH: begin
                stall_up = 1'b1;
            end
            default: begin
                rf_ex_en = 1'b1;
            end
        endcase
    end

    assign ctrl_state = r_state;

    sat_cnt16 u_stall_cnt (
        .i_clk (clk),
        .i_clr (rst),
        .i_inc (stall_up),
        .o_cnt (stall_cnt)
    );

endmodule

// File: tb/tb_rf_ex_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rf_ex_ctrl
// Scoreboard bench for rf_ex_ctrl. A driver applies one input vector per
// cycle, asks a behavioural model what the outputs must be in that cycle and
// queues the answer; a monitor pops each entry and compares it with the DUT.
// The model tracks remaining multiply stall cycles, an outstanding-access
// flag, a one-cycle bubble flag and a capped stall total, and derives the
// visible mode from those.
// ---------------------------------------------------------------------------
module tb_rf_ex_ctrl;

    localparam int MULT_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  issue_vld;
    logic        addr_mem_op;
    logic        dcache_rdy;
    logic        flush;
    logic        rf_ex_en;
    logic [3:0]  fu_vld_out;
    logic        stall_up;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    rf_ex_ctrl #(.MULT_LAT(MULT_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_vld   (issue_vld),
        .addr_mem_op (addr_mem_op),
        .dcache_rdy  (dcache_rdy),
        .flush       (flush),
        .rf_ex_en    (rf_ex_en),
        .fu_vld_out  (fu_vld_out),
        .stall_up    (stall_up),
        .ctrl_state  (ctrl_state),
        .stall_cnt   (stall_cnt)
    );

    typedef struct {
        logic        en;
        logic [3:0]  fu;
        logic        stall;
        logic [1:0]  st;
        logic [15:0] cnt;
        logic        pend;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_mult_left = 0;
    bit m_pend      = 1'b0;
    bit m_bubble    = 1'b0;
    int m_cnt       = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs after the falling edge, predict, advance model.
    task automatic step(input logic [3:0] iv, input logic mem, input logic rdy,
                        input logic fl, input logic r);
        exp_t e;
        int   mode;
        bit   cap;
        @(negedge clk);
        issue_vld   = iv;
        addr_mem_op = mem;
        dcache_rdy  = rdy;
        flush       = fl;
        rst         = r;
        #1;
        if (r) begin
            m_mult_left = 0;
            m_pend      = 1'b0;
            m_bubble    = 1'b0;
            m_cnt       = 0;
        end
        if (m_bubble)             mode = 3;
        else if (m_mult_left > 0) mode = 1;
        else if (m_pend)          mode = 2;
        else                      mode = 0;
        e.en    = (mode == 0) || (mode == 3);
        e.stall = (mode != 0);
        e.fu    = (mode == 0 && !(fl && !r)) ? iv : 4'b0000;
        e.st    = 2'(mode);
        e.cnt   = 16'(m_cnt);
        e.pend  = m_pend;
        sb.push_back(e);
        if (!r) begin
            if (e.stall && m_cnt < 65535) m_cnt++;
            if (fl) begin
                m_bubble    = 1'b1;
                m_mult_left = 0;
                m_pend      = 1'b0;
            end else begin
                cap      = (mode == 0);
                m_bubble = 1'b0;
                if (m_mult_left > 0) m_mult_left--;
                if (cap && iv[2]) m_mult_left = MULT_LAT - 1;
                if (cap && iv[3] && mem) m_pend = 1'b1;
                if (rdy) m_pend = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare whatever the DUT presents against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rf_ex_en",   32'(rf_ex_en),        32'(e.en));
                chk("fu_vld_out", 32'(fu_vld_out),      32'(e.fu));
                chk("stall_up",   32'(stall_up),        32'(e.stall));
                chk("ctrl_state", 32'(ctrl_state),      32'(e.st));
                chk("stall_cnt",  32'(stall_cnt),       32'(e.cnt));
                chk("mem_pend",   32'(dut.r_mem_pend),  32'(e.pend));
            end
        end
    end

    initial begin
        rst = 1'b1; issue_vld = '0; addr_mem_op = 1'b0; dcache_rdy = 1'b0; flush = 1'b0;

        // Reset, including flush and valids during reset
        step(4'b1111, 1'b1, 1'b0, 1'b1, 1'b1);
        step(4'b0101, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Multiply: two stall cycles then RUN
        step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Memory access held four cycles in MEM
        step(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Memory access completing in its capture cycle: no MEM visit
        step(4'b1000, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Mult + mem together, ready pulsed during MULT: no MEM visit
        step(4'b1100, 1'b1, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Mult + mem together, ready late: MEM follows MULT
        step(4'b1100, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Flush in the second MULT cycle
        step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Flush coincident with full issue, then flush held two cycles
        step(4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Reset mid-MULT
        step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(4'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
        end
        idle(4);

        // Continuous stall beyond the counter range: must stick at FFFF
        for (int i = 0; i < 70000; i++) step(4'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Reset mid-MEM clears state and the count; RUN resumes after release
        step(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);

        repeat (3) @(negedge clk);
        #3;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
